multicycle_ctrl: RTL

Sequential control unit for the multi-cycle RV32I datapath. It is the initiator side of the ALU control interface: it issues the 4-bit ALU operation code and operand selects each cycle, and samples the ALU's Zero flag to resolve branches. It sequences fetch, decode, execute, memory and writeback over a request/ready memory handshake. It replaces the single-cycle main decoder when the multi-cycle datapath is built.

---
 rtl/multicycle_ctrl_pkg.sv | 62 ++++++
 rtl/multicycle_ctrl_if.sv | 32 +++
 rtl/multicycle_ctrl_alu_dec.sv | 36 +++
 rtl/multicycle_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, ALU op codes,
// opcodes and datapath select codes. The ALU imports the same ALU op codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StReset    = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAdr   = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExecR    = 4'd7,
    StExecI    = 4'd8,
    StAluWb    = 4'd9,
    StJal      = 4'd10,
    StBranch   = 4'd11,
    StIllegal  = 4'd12
  } state_e;

  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluXor   = 4'b0010;
  localparam logic [3:0] AluAnd   = 4'b0011;
  localparam logic [3:0] AluPassB = 4'b0100;
  localparam logic [3:0] AluBne   = 4'b0101;
  localparam logic [3:0] AluBeq   = 4'b0111;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResRdata  = 2'b01;
  localparam logic [1:0] ResAluRes = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  function automatic logic [1:0] imm_src(input logic [6:0] opcode);
    case (opcode)
      OpStore:  return ImmS;
      OpBranch: return ImmB;
      OpJal:    return ImmJ;
      default:  return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit bundle: instruction/flag/memory-ready inputs and all datapath controls.
// master = the control unit, slave = the datapath and memory it drives.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        Zero;
  logic        mem_ready;
  logic        mem_req;
  logic        AdrSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic [3:0]  ALUctrl;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [1:0]  ResultSrc;
  logic        illegal;
  logic [3:0]  state_dbg;

  modport master (
    input  instr, Zero, mem_ready,
    output mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, ALUctrl,
           ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, illegal, state_dbg
  );

  modport slave (
    output instr, Zero, mem_ready,
    input  mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, ALUctrl,
           ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU sub-decoder: maps opcode/funct3/funct7[5] to an ALU op code, flagging funct3
// values that no supported R-type, I-type ALU or branch instruction uses.
module alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [3:0] o_alu_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_alu_ctrl = AluAdd;
    o_illegal  = 1'b0;
    case (i_opcode)
      OpR, OpI: begin
        case (i_funct3)
          3'b000:  o_alu_ctrl = (i_opcode == OpR && i_funct7_5) ? AluSub : AluAdd;
          3'b100:  o_alu_ctrl = AluXor;
          3'b111:  o_alu_ctrl = AluAnd;
          default: o_illegal  = 1'b1;
        endcase
      end
      OpBranch: begin
        case (i_funct3)
          3'b000:  o_alu_ctrl = AluBeq;
          3'b001:  o_alu_ctrl = AluBne;
          default: o_illegal  = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Build option MC_ILLEGAL_TRAP_EN makes ILLEGAL a sticky terminal trap; otherwise it is a NOP.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  state_e     r_state;
  state_e     w_dispatch;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [3:0] w_alu_ctrl;
  logic       w_dec_illegal;
  logic       w_unused_instr;

  assign w_opcode       = bus.instr[6:0];
  assign w_funct3       = bus.instr[14:12];
  assign w_unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  alu_dec u_alu_dec (
    .i_opcode   (w_opcode),
    .i_funct3   (w_funct3),
    .i_funct7_5 (bus.instr[30]),
    .o_alu_ctrl (w_alu_ctrl),
    .o_illegal  (w_dec_illegal)
  );

  always_comb begin
    w_dispatch = StIllegal;
    case (w_opcode)
      OpLoad:   if (w_funct3 == 3'b010) w_dispatch = StMemAdr;
      OpStore:  w_dispatch = StMemAdr;
      OpR:      if (!w_dec_illegal) w_dispatch = StExecR;
      OpI:      if (!w_dec_illegal) w_dispatch = StExecI;
      OpBranch: if (!w_dec_illegal) w_dispatch = StBranch;
      OpJal:    w_dispatch = StJal;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StReset;
    end else begin
      case (r_state)
        StReset:    r_state <= StFetch;
        StFetch:    if (bus.mem_ready) r_state <= StDecode;
        StDecode:   r_state <= w_dispatch;
        StMemAdr:   r_state <= (w_opcode == OpLoad) ? StMemRead : StMemWrite;
        StMemRead:  if (bus.mem_ready) r_state <= StMemWb;
        StMemWb:    r_state <= StFetch;
        StMemWrite: if (bus.mem_ready) r_state <= StFetch;
        StExecR:    r_state <= StAluWb;
        StExecI:    r_state <= StAluWb;
        StAluWb:    r_state <= StFetch;
        StJal:      r_state <= StAluWb;
        StBranch:   r_state <= StFetch;
`ifdef MC_ILLEGAL_TRAP_EN
        StIllegal:  r_state <= StIllegal;
`else
        StIllegal:  r_state <= StFetch;
`endif
        default:    r_state <= StReset;
      endcase
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (r_state == StDecode && w_dispatch == StIllegal) begin
      r_illegal <= 1'b1;
    end
  end

  assign bus.illegal = r_illegal;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.state_dbg = r_state;

  // Moore decode, except FETCH write strobes (mem_ready) and BRANCH PCWrite (Zero).
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.ALUctrl   = AluAdd;
    bus.ALUSrcA   = SrcAPc;
    bus.ALUSrcB   = SrcBRs2;
    bus.ImmSrc    = ImmI;
    bus.ResultSrc = ResAluOut;
    case (r_state)
      StFetch: begin
        bus.mem_req   = 1'b1;
        bus.ALUSrcB   = SrcBFour;
        bus.ResultSrc = ResAluRes;
        bus.IRWrite   = bus.mem_ready;
        bus.PCWrite   = bus.mem_ready;
      end
      StDecode: begin
        bus.ALUSrcA = SrcAOldPc;
        bus.ALUSrcB = SrcBImm;
        bus.ImmSrc  = imm_src(w_opcode);
      end
      StMemAdr: begin
        bus.ALUSrcA = SrcARs1;
        bus.ALUSrcB = SrcBImm;
      end
      StMemRead: begin
        bus.mem_req = 1'b1;
        bus.AdrSrc  = 1'b1;
      end
      StMemWb: begin
        bus.ResultSrc = ResRdata;
        bus.RegWrite  = 1'b1;
      end
      StMemWrite: begin
        bus.mem_req  = 1'b1;
        bus.MemWrite = 1'b1;
        bus.AdrSrc   = 1'b1;
      end
      StExecR: begin
        bus.ALUSrcA = SrcARs1;
        bus.ALUctrl = w_alu_ctrl;
      end
      StExecI: begin
        bus.ALUSrcA = SrcARs1;
        bus.ALUSrcB = SrcBImm;
        bus.ALUctrl = w_alu_ctrl;
      end
      StAluWb: bus.RegWrite = 1'b1;
      StJal: begin
        bus.ALUSrcA = SrcAOldPc;
        bus.ALUSrcB = SrcBFour;
        bus.PCWrite = 1'b1;
      end
      StBranch: begin
        bus.ALUSrcA = SrcARs1;
        bus.ALUctrl = w_alu_ctrl;
        bus.PCWrite = ~bus.Zero;
      end
      default: ;
    endcase
  end

endmodule
